// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DATA_W   - datapath width (16)
//   SLICE_W  - width of one first-level lookahead slice (4)
//   N_SLICES - number of slices making up the word
//   word_t   - full datapath word
//   slice_t  - one slice worth of bits
package alu_pkg;

  localparam int DATA_W   = 16;
  localparam int SLICE_W  = 4;
  localparam int N_SLICES = DATA_W / SLICE_W;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [SLICE_W-1:0] slice_t;

endpackage : alu_pkg

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead slice: sum bits plus slice propagate/generate.
// Latency: combinational, zero cycles.
// Backpressure: none (pure datapath).
//
// Ports:
//   a, b  in  4  operand bits for this slice
//   cin   in  1  carry into the slice (from the second-level lookahead)
//   sum   out 4  slice sum bits
//   Pg    out 1  slice propagate: every bit propagates
//   Gg    out 1  slice generate: slice produces a carry out with cin=0
//
// The slice never exports its own carry out; the top derives all slice
// carries from Pg/Gg so there is no ripple between slices.
module cla_4b
  import alu_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   cin,
  output slice_t sum,
  output logic   Pg,
  output logic   Gg
);

  slice_t w_p;
  slice_t w_g;
  slice_t w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Internal carries, each a flat sum of products of p/g and cin.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;

  assign Pg = &w_p;
  assign Gg = w_g[3]
            | (w_p[3] & w_g[2])
            | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_4b

// File: rtl/cla_16b.sv
// 16-bit two-level carry-lookahead adder with a registered result copy.
// Latency: sum/cout/ovf/P/G combinational (0 cycles); *_q outputs 1 cycle.
// Backpressure: none; registers capture every rising clk, no enable.
//
// Ports:
//   clk     in  1   clock for the registered result stage
//   rst_n   in  1   asynchronous active-low clear of the *_q registers
//   A, B    in  16  operands (unsigned or two's complement)
//   cin     in  1   carry-in (1 for subtract with inverted B)
//   sum     out 16  (A + B + cin) mod 2^16
//   cout    out 1   carry out of bit 15
//   ovf     out 1   signed overflow
//   P, G    out 1   group propagate / generate
//   sum_q, cout_q, ovf_q  out  registered copies of sum/cout/ovf
module cla_16b
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t A,
  input  word_t B,
  input  logic  cin,
  output word_t sum,
  output logic  cout,
  output logic  ovf,
  output logic  P,
  output logic  G,
  output word_t sum_q,
  output logic  cout_q,
  output logic  ovf_q
);

  // Slice-level propagate/generate and slice carry-ins.
  logic [N_SLICES-1:0] w_pk;
  logic [N_SLICES-1:0] w_gk;
  logic [N_SLICES-1:0] w_cs;

  // Bit-level p/g for bits 12..14, used only to form the carry into bit 15.
  logic [2:0] w_p_hi;
  logic [2:0] w_g_hi;
  logic       w_c15;

  // Registered result stage.
  word_t r_sum;
  logic  r_cout;
  logic  r_ovf;

  // --------------------------------------------------------------------
  // First level: four 4-bit lookahead slices.
  // --------------------------------------------------------------------
  for (genvar k = 0; k < N_SLICES; k++) begin : g_slice
    cla_4b u_cla_4b (
      .a   (A[k*SLICE_W +: SLICE_W]),
      .b   (B[k*SLICE_W +: SLICE_W]),
      .cin (w_cs[k]),
      .sum (sum[k*SLICE_W +: SLICE_W]),
      .Pg  (w_pk[k]),
      .Gg  (w_gk[k])
    );
  end

  // --------------------------------------------------------------------
  // Second level: slice carry-ins straight from Pk/Gk/cin, so the worst
  // path is two lookahead levels regardless of operand values.
  // --------------------------------------------------------------------
  assign w_cs[0] = cin;
  assign w_cs[1] = w_gk[0]
                 | (w_pk[0] & cin);
  assign w_cs[2] = w_gk[1]
                 | (w_pk[1] & w_gk[0])
                 | (w_pk[1] & w_pk[0] & cin);
  assign w_cs[3] = w_gk[2]
                 | (w_pk[2] & w_gk[1])
                 | (w_pk[2] & w_pk[1] & w_gk[0])
                 | (w_pk[2] & w_pk[1] & w_pk[0] & cin);

  assign P = &w_pk;
  assign G = w_gk[3]
           | (w_pk[3] & w_gk[2])
           | (w_pk[3] & w_pk[2] & w_gk[1])
           | (w_pk[3] & w_pk[2] & w_pk[1] & w_gk[0]);
  assign cout = G | (P & cin);

  // --------------------------------------------------------------------
  // Overflow: carry into the MSB XOR carry out of the MSB. The carry into
  // bit 15 is rebuilt from the slice-3 carry-in with its own flat SOP
  // rather than exported from the slice, keeping cla_4b's interface minimal.
  // --------------------------------------------------------------------
  assign w_p_hi = A[14:12] ^ B[14:12];
  assign w_g_hi = A[14:12] & B[14:12];

  assign w_c15 = w_g_hi[2]
               | (w_p_hi[2] & w_g_hi[1])
               | (w_p_hi[2] & w_p_hi[1] & w_g_hi[0])
               | (w_p_hi[2] & w_p_hi[1] & w_p_hi[0] & w_cs[3]);

  assign ovf = cout ^ w_c15;

  // --------------------------------------------------------------------
  // Registered copy. Reset clears only these; the adder stays live.
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= sum;
      r_cout <= cout;
      r_ovf  <= ovf;
    end
  end

  assign sum_q  = r_sum;
  assign cout_q = r_cout;
  assign ovf_q  = r_ovf;

endmodule : cla_16b

// File: tb/tb_cla_16b.sv
// Self-checking bench for cla_16b against an arithmetic reference model.
// Latency: checks combinational outputs 1 unit after apply, *_q after a rising edge.
// Backpressure: n/a.
module tb_cla_16b;
  import alu_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  word_t A;
  word_t B;
  logic  cin;
  word_t sum;
  logic  cout;
  logic  ovf;
  logic  P;
  logic  G;
  word_t sum_q;
  logic  cout_q;
  logic  ovf_q;

  int n_checks = 0;
  int n_fail   = 0;

  cla_16b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf),
    .P      (P),
    .G      (G),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  always #20 clk = ~clk;

  // Reference model: plain integer arithmetic and sign rules.
  // Packs {sum[15:0], cout, ovf, P, G}.
  function automatic logic [19:0] ref_model(input word_t a, input word_t b, input logic ci);
    logic [16:0] full;
    logic [16:0] nocin;
    logic        v;
    logic        pp;
    logic        gg;
    full  = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    nocin = {1'b0, a} + {1'b0, b};
    // Signed overflow: same-sign operands giving a result of the other sign.
    v     = (a[15] == b[15]) && (full[15] != a[15]);
    pp    = ((a ^ b) == 16'hFFFF);
    gg    = nocin[16];
    return {full[15:0], full[16], v, pp, gg};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    A = 16'h0F0F; B = 16'h1111; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({sum_q, cout_q, ovf_q} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got sum_q=%h cout_q=%b ovf_q=%b, want 0/0/0", sum_q, cout_q, ovf_q);
    end
    n_checks++;
    if (sum !== 16'h2021) begin
      n_fail++;
      $display("FAIL reset_comb_sum: got %h want 2021", sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_low();
    logic [19:0] exp_v;
    int          shown = 0;
    cin = 1'b0;
    for (int a = 0; a < 512; a++) begin
      for (int b = 0; b < 512; b++) begin
        A = word_t'(a);
        B = word_t'(b);
        #1;
        exp_v = ref_model(A, B, 1'b0);
        n_checks++;
        if (sum !== exp_v[19:4]) begin
          n_fail++;
          if (shown < 10) begin
            shown++;
            $display("FAIL exhaustive_sum: A=%h B=%h got %h want %h", A, B, sum, exp_v[19:4]);
          end
        end
        #3;
      end
    end
  endtask

  task automatic test_carry_chain();
    A = 16'hFFFF; B = 16'h0001; cin = 1'b0;
    #1;
    n_checks++;
    if ({sum, cout, ovf, P, G} !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL carry_gen: got sum=%h cout=%b ovf=%b P=%b G=%b, want 0000 1 0 0 1", sum, cout, ovf, P, G);
    end
    #3;
    A = 16'hFFFF; B = 16'h0000; cin = 1'b1;
    #1;
    n_checks++;
    if ({sum, cout, P, G} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL carry_prop: got sum=%h cout=%b P=%b G=%b, want 0000 1 1 0", sum, cout, P, G);
    end
    #3;
  endtask

  task automatic test_signed_overflow();
    A = 16'h7FFF; B = 16'h0001; cin = 1'b0;
    #1;
    n_checks++;
    if ({sum, ovf, cout} !== {16'h8000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_pos: got sum=%h ovf=%b cout=%b, want 8000 1 0", sum, ovf, cout);
    end
    #3;
    A = 16'h8000; B = 16'h8000; cin = 1'b0;
    #1;
    n_checks++;
    if ({sum, ovf, cout} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL ovf_neg: got sum=%h ovf=%b cout=%b, want 0000 1 1", sum, ovf, cout);
    end
    #3;
    // Overflow only via carry-in: 0x7FFF + 0 + 1.
    A = 16'h7FFF; B = 16'h0000; cin = 1'b1;
    #1;
    n_checks++;
    if ({sum, ovf, cout} !== {16'h8000, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ovf_cin: got sum=%h ovf=%b cout=%b, want 8000 1 0", sum, ovf, cout);
    end
    #3;
  endtask

  task automatic test_subtract();
    A = 16'd100; B = ~16'd30; cin = 1'b1;
    #1;
    n_checks++;
    if ({sum, cout, ovf} !== {16'd70, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL subtract: got sum=%0d cout=%b ovf=%b, want 70 1 0", sum, cout, ovf);
    end
    #3;
  endtask

  task automatic test_registered();
    @(negedge clk);
    A = 16'h0F0F; B = 16'h0101; cin = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (sum_q !== 16'h1010) begin
      n_fail++;
      $display("FAIL reg_first: got sum_q=%h want 1010", sum_q);
    end
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; cin = 1'b0;
    #1;
    n_checks++;
    if (sum_q !== 16'h1010) begin
      n_fail++;
      $display("FAIL reg_hold: got sum_q=%h want 1010 before edge", sum_q);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sum_q !== 16'h2345) begin
      n_fail++;
      $display("FAIL reg_capture: got sum_q=%h want 2345", sum_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] exp_v;
    @(negedge clk);
    A = 16'hFFFF; B = 16'h8001; cin = 1'b1;
    @(posedge clk);
    #1;
    exp_v = ref_model(16'hFFFF, 16'h8001, 1'b1);
    n_checks++;
    if ({sum_q, cout_q, ovf_q} !== {exp_v[19:4], exp_v[3], exp_v[2]}) begin
      n_fail++;
      $display("FAIL mid_preload: got %h/%b/%b want %h/%b/%b", sum_q, cout_q, ovf_q, exp_v[19:4], exp_v[3], exp_v[2]);
    end
    // Assert reset between edges; registers must clear without a clock.
    #5;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sum_q, cout_q, ovf_q} !== 18'd0) begin
      n_fail++;
      $display("FAIL mid_async_clear: got sum_q=%h cout_q=%b ovf_q=%b want 0", sum_q, cout_q, ovf_q);
    end
    n_checks++;
    if (sum !== exp_v[19:4]) begin
      n_fail++;
      $display("FAIL mid_comb_live: got sum=%h want %h", sum, exp_v[19:4]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({sum_q, cout_q, ovf_q} !== 18'd0) begin
      n_fail++;
      $display("FAIL mid_reset_held: got sum_q=%h want 0", sum_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h4000; B = 16'h4000; cin = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({sum_q, cout_q, ovf_q} !== {16'h8000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_release_capture: got %h/%b/%b want 8000/0/1", sum_q, cout_q, ovf_q);
    end
  endtask

  // Random back-to-back operands: new vector every cycle, combinational
  // check mid-cycle and registered check just after the following edge.
  task automatic test_back_to_back();
    logic [19:0] exp_v;
    int          shown = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      A   = word_t'($urandom);
      B   = word_t'($urandom);
      cin = 1'($urandom);
      if (i % 8 == 0) B = ~A;
      #1;
      exp_v = ref_model(A, B, cin);
      n_checks++;
      if ({sum, cout, ovf, P, G} !== exp_v) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_comb: A=%h B=%h cin=%b got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
                   A, B, cin, sum, cout, ovf, P, G,
                   exp_v[19:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({sum_q, cout_q, ovf_q} !== exp_v[19:2]) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL rand_reg: A=%h B=%h cin=%b got %h/%b/%b want %h/%b/%b",
                   A, B, cin, sum_q, cout_q, ovf_q, exp_v[19:4], exp_v[3], exp_v[2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive_low();
    test_carry_chain();
    test_signed_overflow();
    test_subtract();
    test_registered();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_16b
